five_stage_hazard_controller: RTL and testbench
===============================================

# five_stage_hazard_controller

Hazard and bypass controller for the five-stage core. It tracks the destination registers of the instructions in execute, memory and writeback, and drives the decode stage's `rs1_data_bypass`/`rs2_data_bypass` selects. It also generates the load-use stall, the ID/EX bubble and the branch flush. It sits beside the decode unit and is clocked with the pipeline registers.

## Interface
- `CORE`, 0, core index; unused by logic, kept for hierarchy uniformity
- `REG_BITS`, 5, register-address width
- `COUNT_WIDTH`, 32, width of the stall/flush performance counters
- `clock`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-low reset
- `hold`  in  1  external memory wait; freezes all internal state and counters
- `id_valid`  in  1  decode holds a real instruction
- `id_rs1`, `id_rs2`  in  REG_BITS  decode source registers
- `id_uses_rs1`, `id_uses_rs2`  in  1  instruction reads that source
- `id_rd`  in  REG_BITS  decode destination
- `id_regwrite`  in  1  decode instruction writes `id_rd`
- `id_load`  in  1  decode instruction is a load
- `ex_branch_taken`  in  1  execute resolved a taken branch/JAL/JALR
- `rs1_data_bypass`, `rs2_data_bypass`  out  2  00 regfile, 01 execute, 10 memory, 11 writeback
- `stall`  out  1  hold PC and IF/ID register
- `ex_bubble`  out  1  load NOP into ID/EX register
- `flush`  out  1  squash IF/ID contents
- `stall_count`, `flush_count`  out  COUNT_WIDTH  saturating event counters

## Operation
- Three tracking slots: EX, MEM, WB. Each slot holds {valid, rd, regwrite, load}.
- A slot is a write candidate when valid & regwrite & rd≠0.
- Normal advance: EX←decode fields (valid = id_valid), MEM←EX, WB←MEM.
- Bypass select per source. Register x0 or an unused source gives 00.
  - Otherwise the youngest matching candidate wins: EX→01, MEM→10, WB→11; no match gives 00.
- Load data is valid only from writeback, so:
  - Load-use hazard: id_valid and a used source matches a load candidate in EX or MEM.
  - On a hazard: `stall`=1 and `ex_bubble`=1. The EX slot gets valid=0; MEM←EX and WB←MEM still advance.
  - A load in EX therefore stalls 2 cycles; a load in MEM stalls 1.
- Flush: `ex_branch_taken`=1 forces `flush`=1 and `ex_bubble`=1, and the EX slot gets valid=0.
  - `stall` is forced 0; flush wins over stall because the stalled instruction is wrong-path.
- `hold`=1: all slots and counters keep their values; `stall`, `ex_bubble` and `flush` are forced 0.
  - The bypass selects still evaluate against the frozen slots.
- `stall_count` increments on each cycle with `stall`=1; `flush_count` on each cycle with `flush`=1. Both saturate at all-ones.

## Timing
- Bypass selects, `stall`, `ex_bubble` and `flush` are combinational from the decode inputs and registered slots, valid in the same cycle.
- Slots and counters update on the rising `clock` edge.
- Reset (asserted asynchronously, released synchronously by the surrounding reset synchroniser): all slots go invalid, counters go to 0, all bypass selects read 00, and `stall`, `ex_bubble` and `flush` read 0.
- Reset mid-stall aborts the stall immediately; the next decode instruction sees empty slots.
- `ex_branch_taken` and a load-use hazard in the same cycle give one flush cycle and no stall.
- A hazard where both sources match different stages takes the longer stall, because the condition is re-evaluated every cycle.

## Configuration
- `HAZARD_BYPASS_EN` defined: forwarding as above.
- `HAZARD_BYPASS_EN` undefined:
  - Bypass selects are tied to 00.
  - Any used-source match against any write candidate in EX, MEM or WB stalls, not just loads.
  - Worst-case RAW stall is 3 cycles; flush behaviour is unchanged.

## Structure
- Shared package holds:
  - Bypass encoding constants `BYPASS_REGFILE`/`BYPASS_EXECUTE`/`BYPASS_MEMORY`/`BYPASS_WRITEBACK`.
  - The slot record typedef {valid, rd, regwrite, load}.
- Sub-module `hazard_source_match`, instantiated once per source: takes a source and its use flag plus the three slots, and returns the bypass select and load-hazard flag.

## Test plan
- `addi x5` in EX, decode `add x6,x5,x0` (uses_rs1) → `rs1_data_bypass`=01, `rs2_data_bypass`=00, no stall.
- x5 written in both EX and WB, decode reads x5 → 01. After one bubble cycle the writer is in MEM → 10.
- Decode `lw x7`, then decode `add x8,x7,x7` → `stall`=1 for 2 cycles, `ex_bubble`=1 both cycles, then both selects 11; `stall_count`=2.
- Load-use hazard with `ex_branch_taken`=1 in the same cycle → `flush`=1, `stall`=0, `flush_count`=1, and the EX slot goes invalid.
- Decode writes x0, next instruction reads x0 → selects 00. With `hold`=1 for 3 cycles, slots and counters are unchanged.
- `HAZARD_BYPASS_EN` undefined, `addi x5` then a reader of x5 → `stall`=1 for 3 cycles, selects always 00. Assert `reset` low mid-stall → `stall`=0 at once, counters 0.

Source files
------------

// File: rtl/five_stage_hazard_controller_pkg.sv
// Shared types for the five-stage hazard/bypass controller: bypass select encoding
// and the per-stage tracking slot record.
package five_stage_hazard_controller_pkg;

  // Slots carry register addresses at this width; narrower REG_BITS are zero-extended.
  localparam int SLOT_RD_BITS = 8;

  localparam logic [1:0] BYPASS_REGFILE   = 2'b00;
  localparam logic [1:0] BYPASS_EXECUTE   = 2'b01;
  localparam logic [1:0] BYPASS_MEMORY    = 2'b10;
  localparam logic [1:0] BYPASS_WRITEBACK = 2'b11;

  typedef struct packed {
    logic                    valid;
    logic [SLOT_RD_BITS-1:0] rd;
    logic                    regwrite;
    logic                    load;
  } hazard_slot_t;

  localparam hazard_slot_t SLOT_EMPTY = '0;

  function automatic logic is_write_candidate(input hazard_slot_t s);
    return s.valid && s.regwrite && (s.rd != '0);
  endfunction

endpackage

// File: rtl/five_stage_hazard_controller_source_match.sv
// Per-source matcher: compares one decode source against the EX/MEM/WB slots and
// yields its bypass select and hazard flag. Forwarding enabled by HAZARD_BYPASS_EN.
module hazard_source_match
  import five_stage_hazard_controller_pkg::*;
(
  input  logic [SLOT_RD_BITS-1:0] src_i,
  input  logic                    use_i,
  input  hazard_slot_t            slot_ex_i,
  input  hazard_slot_t            slot_mem_i,
  input  hazard_slot_t            slot_wb_i,
  output logic [1:0]              bypass_o,
  output logic                    hazard_o
);

  logic src_live;
  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  assign src_live = use_i && (src_i != '0);
  assign hit_ex   = src_live && is_write_candidate(slot_ex_i)  && (slot_ex_i.rd  == src_i);
  assign hit_mem  = src_live && is_write_candidate(slot_mem_i) && (slot_mem_i.rd == src_i);
  assign hit_wb   = src_live && is_write_candidate(slot_wb_i)  && (slot_wb_i.rd  == src_i);

`ifdef HAZARD_BYPASS_EN
  always_comb begin
    bypass_o = BYPASS_REGFILE;
    if (hit_ex) begin
      bypass_o = BYPASS_EXECUTE;
    end else if (hit_mem) begin
      bypass_o = BYPASS_MEMORY;
    end else if (hit_wb) begin
      bypass_o = BYPASS_WRITEBACK;
    end
  end

  // Load data only exists at writeback, so a load still in EX or MEM must stall.
  assign hazard_o = (hit_ex && slot_ex_i.load) || (hit_mem && slot_mem_i.load);
`else
  assign bypass_o = BYPASS_REGFILE;
  assign hazard_o = hit_ex || hit_mem || hit_wb;
`endif

endmodule

// File: rtl/five_stage_hazard_controller.sv
// Hazard and bypass controller for the five-stage core: tracks EX/MEM/WB destinations,
// drives bypass selects, load-use stall, ID/EX bubble and branch flush. Macro: HAZARD_BYPASS_EN.
module five_stage_hazard_controller
  import five_stage_hazard_controller_pkg::*;
#(
  parameter int CORE        = 0,
  parameter int REG_BITS    = 5,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   hold,
  input  logic                   id_valid,
  input  logic [REG_BITS-1:0]    id_rs1,
  input  logic [REG_BITS-1:0]    id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [REG_BITS-1:0]    id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_load,
  input  logic                   ex_branch_taken,
  output logic [1:0]             rs1_data_bypass,
  output logic [1:0]             rs2_data_bypass,
  output logic                   stall,
  output logic                   ex_bubble,
  output logic                   flush,
  output logic [COUNT_WIDTH-1:0] stall_count,
  output logic [COUNT_WIDTH-1:0] flush_count
);

  if (REG_BITS < 1 || REG_BITS > SLOT_RD_BITS || CORE < 0) begin : g_bad_params
    $error("five_stage_hazard_controller: unsupported REG_BITS or CORE");
  end

  hazard_slot_t ex_q, ex_d;
  hazard_slot_t mem_q, mem_d;
  hazard_slot_t wb_q, wb_d;
  logic [COUNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [COUNT_WIDTH-1:0] flush_count_q, flush_count_d;

  logic [1:0][REG_BITS-1:0] src_reg;
  logic [1:0]               src_use;
  logic [1:0][1:0]          src_bypass;
  logic [1:0]               src_hazard;

  assign src_reg = {id_rs2, id_rs1};
  assign src_use = {id_uses_rs2, id_uses_rs1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    hazard_source_match u_match (
      .src_i      (SLOT_RD_BITS'(src_reg[gi])),
      .use_i      (src_use[gi]),
      .slot_ex_i  (ex_q),
      .slot_mem_i (mem_q),
      .slot_wb_i  (wb_q),
      .bypass_o   (src_bypass[gi]),
      .hazard_o   (src_hazard[gi])
    );
  end

  assign rs1_data_bypass = src_bypass[0];
  assign rs2_data_bypass = src_bypass[1];
  assign stall_count     = stall_count_q;
  assign flush_count     = flush_count_q;

  always_comb begin
    logic active;
    active    = reset && !hold;
    // A taken branch squashes the stalled instruction, so flush wins over stall.
    flush     = active && ex_branch_taken;
    stall     = active && id_valid && (|src_hazard) && !ex_branch_taken;
    ex_bubble = stall || flush;
  end

  always_comb begin
    ex_d          = ex_q;
    mem_d         = mem_q;
    wb_d          = wb_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!hold) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (ex_bubble) begin
        ex_d = SLOT_EMPTY;
      end else begin
        ex_d.valid    = id_valid;
        ex_d.rd       = SLOT_RD_BITS'(id_rd);
        ex_d.regwrite = id_regwrite;
        ex_d.load     = id_load;
      end
      if (stall && (stall_count_q != '1)) begin
        stall_count_d = stall_count_q + COUNT_WIDTH'(1);
      end
      if (flush && (flush_count_q != '1)) begin
        flush_count_d = flush_count_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q          <= SLOT_EMPTY;
      mem_q         <= SLOT_EMPTY;
      wb_q          <= SLOT_EMPTY;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

endmodule

// File: tb/tb_five_stage_hazard_controller.sv
// Randomised self-checking bench for five_stage_hazard_controller with an in-bench
// pipeline-history model plus directed literal scenarios; honours HAZARD_BYPASS_EN.
module tb_five_stage_hazard_controller;

  localparam int RB   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock, reset, hold, id_valid;
  logic [RB-1:0] id_rs1, id_rs2, id_rd;
  logic          id_uses_rs1, id_uses_rs2, id_regwrite, id_load, ex_branch_taken;
  logic [1:0]    rs1_data_bypass, rs2_data_bypass;
  logic          stall, ex_bubble, flush;
  logic [CW-1:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  five_stage_hazard_controller #(.CORE(0), .REG_BITS(RB), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .hold(hold), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_load(id_load),
    .ex_branch_taken(ex_branch_taken),
    .rs1_data_bypass(rs1_data_bypass), .rs2_data_bypass(rs2_data_bypass),
    .stall(stall), .ex_bubble(ex_bubble), .flush(flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: hist[0] is the youngest in-flight instruction (EX), hist[2] the oldest (WB).
  logic          hv [3];
  logic [RB-1:0] hrd[3];
  logic          hrw[3];
  logic          hld[3];
  int            scnt, fcnt;

  function automatic void model_outs(output logic [1:0] s1, output logic [1:0] s2,
                                     output logic st, output logic bub, output logic fl);
    logic hz;
    hz = 1'b0;
    s1 = 2'd0;
    s2 = 2'd0;
    for (int s = 0; s < 2; s++) begin
      logic [RB-1:0] r;
      logic u, found, ld_hit, any_hit;
      int first;
      r = (s == 0) ? id_rs1 : id_rs2;
      u = (s == 0) ? id_uses_rs1 : id_uses_rs2;
      found = 1'b0; ld_hit = 1'b0; any_hit = 1'b0; first = 0;
      if (u && r != 0) begin
        for (int i = 0; i < 3; i++) begin
          if (hv[i] && hrw[i] && hrd[i] != 0 && hrd[i] == r) begin
            if (!found) begin found = 1'b1; first = i + 1; end
            if (i < 2 && hld[i]) ld_hit = 1'b1;
            any_hit = 1'b1;
          end
        end
      end
      if (BYP) begin
        if (s == 0) s1 = 2'(first); else s2 = 2'(first);
        hz = hz | ld_hit;
      end else begin
        hz = hz | any_hit;
      end
    end
    hz  = hz && id_valid;
    fl  = reset && !hold && ex_branch_taken;
    st  = reset && !hold && hz && !ex_branch_taken;
    bub = st || fl;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) hv[i] <= 1'b0;
      scnt <= 0;
      fcnt <= 0;
    end else if (!hold) begin
      logic [1:0] m1, m2;
      logic mst, mbub, mfl;
      model_outs(m1, m2, mst, mbub, mfl);
      hv[2] <= hv[1]; hrd[2] <= hrd[1]; hrw[2] <= hrw[1]; hld[2] <= hld[1];
      hv[1] <= hv[0]; hrd[1] <= hrd[0]; hrw[1] <= hrw[0]; hld[1] <= hld[0];
      hv[0] <= id_valid && !mbub; hrd[0] <= id_rd; hrw[0] <= id_regwrite; hld[0] <= id_load;
      if (mst && scnt < CMAX) scnt <= scnt + 1;
      if (mfl && fcnt < CMAX) fcnt <= fcnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [1:0] e1, e2;
    logic est, ebub, efl;
    model_outs(e1, e2, est, ebub, efl);
    chk("cyc.rs1_bypass", int'(rs1_data_bypass), int'(e1));
    chk("cyc.rs2_bypass", int'(rs2_data_bypass), int'(e2));
    chk("cyc.stall", int'(stall), int'(est));
    chk("cyc.ex_bubble", int'(ex_bubble), int'(ebub));
    chk("cyc.flush", int'(flush), int'(efl));
    chk("cyc.stall_count", int'(stall_count), scnt);
    chk("cyc.flush_count", int'(flush_count), fcnt);
  end

  // Literal expectations checked against both the DUT and the model.
  task automatic expect_outs(input string tag, input int s1, input int s2,
                             input int st, input int bub, input int fl);
    logic [1:0] m1, m2;
    logic mst, mbub, mfl;
    model_outs(m1, m2, mst, mbub, mfl);
    $display("txn %s: sel=%0d/%0d stall=%0d bubble=%0d flush=%0d", tag,
             rs1_data_bypass, rs2_data_bypass, stall, ex_bubble, flush);
    chk({tag, ".rs1"}, int'(rs1_data_bypass), s1);
    chk({tag, ".rs2"}, int'(rs2_data_bypass), s2);
    chk({tag, ".stall"}, int'(stall), st);
    chk({tag, ".bubble"}, int'(ex_bubble), bub);
    chk({tag, ".flush"}, int'(flush), fl);
    chk({tag, ".model_rs1"}, int'(m1), s1);
    chk({tag, ".model_stall"}, int'(mst), st);
    chk({tag, ".model_flush"}, int'(mfl), fl);
  endtask

  task automatic set_id(input logic v, input int rs1, input logic u1, input int rs2,
                        input logic u2, input int rd, input logic rw, input logic ld);
    id_valid = v; id_rs1 = RB'(rs1); id_uses_rs1 = u1; id_rs2 = RB'(rs2); id_uses_rs2 = u2;
    id_rd = RB'(rd); id_regwrite = rw; id_load = ld;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  int c0, f0;

  initial begin
    reset = 1'b0; hold = 1'b0; ex_branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    expect_outs("reset", 0, 0, 0, 0, 0);
    chk("reset.stall_count", int'(stall_count), 0);
    chk("reset.flush_count", int'(flush_count), 0);
    next_cycle();
    reset = 1'b1;

    // addi x5 then a reader of x5
    set_id(1, 0, 1, 0, 0, 5, 1, 0);
    next_cycle();
    set_id(1, 5, 1, 0, 1, 6, 1, 0);
    if (BYP) begin
      sample();
      expect_outs("raw_ex", 1, 0, 0, 0, 0);
      // x5 written in both EX and WB; a flush bubble then leaves the writer in MEM
      next_cycle(); set_id(1, 0, 1, 0, 0, 5, 1, 0);
      next_cycle(); set_id(1, 0, 1, 0, 0, 11, 1, 0);
      next_cycle(); set_id(1, 0, 1, 0, 0, 5, 1, 0);
      next_cycle(); set_id(1, 5, 1, 0, 1, 6, 1, 0); ex_branch_taken = 1'b1;
      sample();
      expect_outs("ex_and_wb", 1, 0, 0, 1, 1);
      next_cycle(); ex_branch_taken = 1'b0;
      sample();
      expect_outs("mem_after_bubble", 2, 0, 0, 0, 0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        sample();
        expect_outs($sformatf("raw_stall%0d", k), 0, 0, 1, 1, 0);
        next_cycle();
      end
      sample();
      expect_outs("raw_release", 0, 0, 0, 0, 0);
      chk("raw.stall_count", int'(stall_count), 3);
    end

    // lw x7 then add x8,x7,x7
    next_cycle(); set_id(1, 0, 1, 0, 0, 7, 1, 1);
    next_cycle(); set_id(1, 7, 1, 7, 1, 8, 1, 0);
    c0 = int'(stall_count);
    sample();
    expect_outs("lu_ex", BYP ? 1 : 0, BYP ? 1 : 0, 1, 1, 0);
    next_cycle(); sample();
    expect_outs("lu_mem", BYP ? 2 : 0, BYP ? 2 : 0, 1, 1, 0);
    next_cycle(); sample();
    if (BYP) begin
      expect_outs("lu_wb", 3, 3, 0, 0, 0);
      chk("lu.stall_delta", int'(stall_count) - c0, 2);
    end else begin
      expect_outs("lu_wb", 0, 0, 1, 1, 0);
      next_cycle(); sample();
      expect_outs("lu_done", 0, 0, 0, 0, 0);
      chk("lu.stall_delta", int'(stall_count) - c0, 3);
    end

    // load-use and taken branch together: flush only, EX slot squashed
    next_cycle(); set_id(1, 0, 1, 0, 0, 12, 1, 1);
    next_cycle(); set_id(1, 12, 1, 0, 0, 10, 1, 0); ex_branch_taken = 1'b1;
    f0 = int'(flush_count);
    sample();
    expect_outs("lu_flush", BYP ? 1 : 0, 0, 0, 1, 1);
    next_cycle(); ex_branch_taken = 1'b0;
    chk("lu_flush.flush_delta", int'(flush_count) - f0, 1);
    set_id(1, 10, 1, 0, 0, 13, 1, 0);
    sample();
    expect_outs("squashed_rd", 0, 0, 0, 0, 0);

    // x0 writer then x0 reader, then hold for three cycles
    next_cycle(); set_id(1, 0, 1, 0, 1, 0, 1, 0);
    next_cycle(); set_id(1, 0, 1, 0, 1, 14, 1, 0);
    sample();
    expect_outs("x0_read", 0, 0, 0, 0, 0);
    next_cycle(); set_id(1, 13, 1, 13, 1, 15, 1, 0);
    hold = 1'b1; ex_branch_taken = 1'b1;
    c0 = int'(stall_count); f0 = int'(flush_count);
    for (int k = 0; k < 3; k++) begin
      sample();
      expect_outs($sformatf("hold%0d", k), BYP ? 3 : 0, BYP ? 3 : 0, 0, 0, 0);
      next_cycle();
    end
    chk("hold.stall_count", int'(stall_count), c0);
    chk("hold.flush_count", int'(flush_count), f0);
    hold = 1'b0; ex_branch_taken = 1'b0;
    sample();
    expect_outs("post_hold", BYP ? 3 : 0, BYP ? 3 : 0, BYP ? 0 : 1, BYP ? 0 : 1, 0);

    // reset asserted in the middle of a stall
    next_cycle(); set_id(1, 0, 1, 0, 0, 5, 1, 1);
    next_cycle(); set_id(1, 5, 1, 0, 0, 6, 1, 0);
    sample();
    expect_outs("pre_reset", BYP ? 1 : 0, 0, 1, 1, 0);
    #2 reset = 1'b0;
    #1;
    expect_outs("reset_mid", 0, 0, 0, 0, 0);
    chk("reset_mid.stall_count", int'(stall_count), 0);
    chk("reset_mid.flush_count", int'(flush_count), 0);
    next_cycle(); reset = 1'b1;
    sample();
    expect_outs("after_reset", 0, 0, 0, 0, 0);

    // randomised traffic, checked every cycle against the model
    for (int n = 0; n < 4000; n++) begin
      next_cycle();
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0) reset = 1'b0;
      hold            = ($urandom_range(0, 9) == 0);
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 7) != 0, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
    end
    sample();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
